// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-stream sequencer for the sliding-window line buffer and MAC handshake.
// Define CONV_CTRL_STALL_CNT_EN to add the stall_cnt backpressure counter.
module conv_window_ctrl #(
  parameter int C = 4,
  parameter int R = 4,
  parameter int MAXK = 3,
  localparam int K_SIZE = $clog2(MAXK+1),
  localparam int RW = $clog2(R),
  localparam int CW = $clog2(C)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [K_SIZE-1:0] k_in,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              pix_valid,
  output logic              win_clr,
  output logic [K_SIZE-1:0] k_cfg,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              frame_done,
  output logic              busy,
`ifdef CONV_CTRL_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              err
);
  typedef enum logic [1:0] {IDLE, CLR, STREAM, WAIT} state_e;
  state_e state_q, state_d;
  logic [K_SIZE-1:0] k_cfg_q, k_cfg_d;
  logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic err_q, err_d, last_win_q, last_win_d, frame_done_q, frame_done_d;
  logic s_ready_q, win_clr_q, win_valid_q, busy_q;
  logic last_pos, hit, k_ok;
  assign pix_valid = s_valid & s_ready_q;
  assign last_pos = in_row_q == RW'(R-1) && in_col_q == CW'(C-1);
  assign hit = 32'(in_row_q) + 1 >= 32'(k_cfg_q) && 32'(in_col_q) + 1 >= 32'(k_cfg_q);
  assign k_ok = k_in != '0 && 32'(k_in) <= 32'(MAXK);
  always_comb begin
    state_d = state_q;
    k_cfg_d = k_cfg_q;
    err_d = err_q;
    in_row_d = in_row_q;
    in_col_d = in_col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    last_win_d = last_win_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        err_d = !k_ok;
        k_cfg_d = k_ok ? k_in : k_cfg_q;
        state_d = k_ok ? CLR : IDLE;
      end
      CLR: begin
        in_row_d = '0;
        in_col_d = '0;
        state_d = STREAM;
      end
      STREAM: if (pix_valid) begin
        in_col_d = in_col_q == CW'(C-1) ? '0 : in_col_q + 1'b1;
        in_row_d = in_col_q == CW'(C-1) ? in_row_q + 1'b1 : in_row_q;
        err_d = err_q | (s_last != last_pos);
        last_win_d = last_pos;
        out_row_d = hit ? RW'(32'(in_row_q) + 1 - 32'(k_cfg_q)) : out_row_q;
        out_col_d = hit ? CW'(32'(in_col_q) + 1 - 32'(k_cfg_q)) : out_col_q;
        state_d = hit ? WAIT : last_pos ? IDLE : STREAM;
        frame_done_d = !hit && last_pos;
      end
      WAIT: if (win_ready) begin
        state_d = last_win_q ? IDLE : STREAM;
        frame_done_d = last_win_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_cfg_q <= '0;
      err_q <= 1'b0;
      in_row_q <= '0;
      in_col_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      last_win_q <= 1'b0;
      frame_done_q <= 1'b0;
      s_ready_q <= 1'b0;
      win_clr_q <= 1'b0;
      win_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_cfg_q <= k_cfg_d;
      err_q <= err_d;
      in_row_q <= in_row_d;
      in_col_q <= in_col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      last_win_q <= last_win_d;
      frame_done_q <= frame_done_d;
      s_ready_q <= state_d == STREAM;
      win_clr_q <= state_d == CLR;
      win_valid_q <= state_d == WAIT;
      busy_q <= state_d != IDLE;
    end
  end
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb begin
    stall_d = (state_q == IDLE && start && k_ok) ? '0 :
              (state_q == WAIT && !win_ready && stall_q != '1) ? stall_q + 1 : stall_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
  assign s_ready = s_ready_q;
  assign win_clr = win_clr_q;
  assign k_cfg = k_cfg_q;
  assign win_valid = win_valid_q;
  assign out_row = out_row_q;
  assign out_col = out_col_q;
  assign frame_done = frame_done_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule
